// File: rtl/ph_fifo_flag_m.sv
// Single-clock p1->p2 flag FIFO with single/threshold flag modes, flush,
// sticky overflow/underflow and a configurable post-reset fill level.
module ph_fifo_flag_m #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 2,
  parameter int LEVEL      = 2,
  parameter int INIT_COUNT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode_multi,
  input  logic                         p1_select,
  input  logic                         p1_rdnw,
  input  logic [WIDTH-1:0]             p1_data,
  input  logic                         p1_flush,
  input  logic                         p2_select,
  input  logic                         p2_rdnw,
  output logic [WIDTH-1:0]             p2_data,
  output logic                         p2_data_available,
  output logic                         p1_full,
  output logic                         p1_overflow,
  output logic                         p2_underflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LEVEL_C = CNT_W'(LEVEL);
  localparam logic [CNT_W-1:0] INIT_C  = CNT_W'(INIT_COUNT);
  localparam logic [PTR_W-1:0] INIT_WP = PTR_W'(INIT_COUNT % DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] p2_data_q, p2_data_d;
  logic             avail_q, avail_d, full_q, full_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr, rd, rd_ok, wr_ok;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [1:0] flags(input logic [CNT_W-1:0] c, input logic multi);
    logic av, fu;
    if (multi) begin
      av = (c >= LEVEL_C);
      fu = (c == DEPTH_C);
    end else begin
      av = (c != '0);
      fu = (c != '0);
    end
    return {av, fu};
  endfunction

  always_comb begin
    wr        = p1_select & ~p1_rdnw;
    rd        = p2_select & p2_rdnw;
    rd_ok     = rd & (count_q != '0) & ~p1_flush;
    wr_ok     = wr & ~p1_flush & ((count_q != DEPTH_C) | rd_ok);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    p2_data_d = p2_data_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (p1_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (rd_ok) begin
        p2_data_d = mem_q[rd_ptr_q];
        rd_ptr_d  = ptr_inc(rd_ptr_q);
      end
      if (rd && (count_q == '0)) unf_d = 1'b1;
      if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (wr && !wr_ok) ovf_d = 1'b1;
      count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
    {avail_d, full_d} = flags(count_d, mode_multi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= INIT_WP;
      count_q   <= INIT_C;
      p2_data_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      avail_q   <= (INIT_COUNT >= 1);
      full_q    <= (INIT_COUNT >= 1);
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      p2_data_q <= p2_data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      avail_q   <= avail_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= p1_data;
    end
  end

  assign p2_data           = p2_data_q;
  assign p2_data_available = avail_q;
  assign p1_full           = full_q;
  assign p1_overflow       = ovf_q;
  assign p2_underflow      = unf_q;
  assign count             = count_q;

endmodule

// File: tb/tb_ph_fifo_flag_m.sv
// Bench for ph_fifo_flag_m: two configurations driven in lockstep, checked
// every cycle against a list-based model plus directed literal checks.
module tb_ph_fifo_flag_m;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_multi = 1'b0;
  logic       p1_select = 1'b0, p1_rdnw = 1'b0, p1_flush = 1'b0;
  logic [7:0] p1_data = 8'h00;
  logic       p2_select = 1'b0, p2_rdnw = 1'b0;

  logic [7:0] a_data, b_data;
  logic       a_av, a_full, a_ovf, a_unf;
  logic       b_av, b_full, b_ovf, b_unf;
  logic [1:0] a_count, b_count;

  always #5 clk = ~clk;

  ph_fifo_flag_m #(.WIDTH(8), .DEPTH(2), .LEVEL(2), .INIT_COUNT(0)) u_a (
    .clk(clk), .rst(rst), .mode_multi(mode_multi),
    .p1_select(p1_select), .p1_rdnw(p1_rdnw), .p1_data(p1_data), .p1_flush(p1_flush),
    .p2_select(p2_select), .p2_rdnw(p2_rdnw), .p2_data(a_data),
    .p2_data_available(a_av), .p1_full(a_full), .p1_overflow(a_ovf),
    .p2_underflow(a_unf), .count(a_count));

  ph_fifo_flag_m #(.WIDTH(8), .DEPTH(3), .LEVEL(2), .INIT_COUNT(1)) u_b (
    .clk(clk), .rst(rst), .mode_multi(mode_multi),
    .p1_select(p1_select), .p1_rdnw(p1_rdnw), .p1_data(p1_data), .p1_flush(p1_flush),
    .p2_select(p2_select), .p2_rdnw(p2_rdnw), .p2_data(b_data),
    .p2_data_available(b_av), .p1_full(b_full), .p1_overflow(b_ovf),
    .p2_underflow(b_unf), .count(b_count));

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;
  logic mm = 1'b0;

  // Model: contents kept as an ordered list, head at index 0.
  int         dep  [2] = '{2, 3};
  int         lvl  [2] = '{2, 2};
  int         init [2] = '{0, 1};
  int         mcnt [2];
  logic [7:0] mbuf [2][4];
  logic [7:0] mp2  [2];
  logic       movf [2], munf [2], mav [2], mfull [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic mflags(input int k, input logic multi);
    if (multi) begin
      mav[k]   = (mcnt[k] >= lvl[k]);
      mfull[k] = (mcnt[k] == dep[k]);
    end else begin
      mav[k]   = (mcnt[k] >= 1);
      mfull[k] = (mcnt[k] >= 1);
    end
  endtask

  task automatic mstep(input int k);
    bit r, w;
    r = p2_select & p2_rdnw;
    w = p1_select & ~p1_rdnw;
    if (rst) begin
      mcnt[k] = init[k];
      for (int i = 0; i < 4; i++) mbuf[k][i] = 8'h00;
      mp2[k] = 8'h00; movf[k] = 1'b0; munf[k] = 1'b0;
      mflags(k, 1'b0);
    end else if (p1_flush) begin
      mcnt[k] = 0;
      mflags(k, mode_multi);
    end else begin
      if (r) begin
        if (mcnt[k] > 0) begin
          mp2[k] = mbuf[k][0];
          for (int i = 0; i < 3; i++) mbuf[k][i] = mbuf[k][i+1];
          mcnt[k]--;
        end else munf[k] = 1'b1;
      end
      if (w) begin
        if (mcnt[k] < dep[k]) begin
          mbuf[k][mcnt[k]] = p1_data;
          mcnt[k]++;
        end else movf[k] = 1'b1;
      end
      mflags(k, mode_multi);
    end
  endtask

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("A.p2_data", 32'(a_data),  32'(mp2[0]));
      chk("A.count",   32'(a_count), 32'(mcnt[0]));
      chk("A.avail",   32'(a_av),    32'(mav[0]));
      chk("A.full",    32'(a_full),  32'(mfull[0]));
      chk("A.ovf",     32'(a_ovf),   32'(movf[0]));
      chk("A.unf",     32'(a_unf),   32'(munf[0]));
      chk("B.p2_data", 32'(b_data),  32'(mp2[1]));
      chk("B.count",   32'(b_count), 32'(mcnt[1]));
      chk("B.avail",   32'(b_av),    32'(mav[1]));
      chk("B.full",    32'(b_full),  32'(mfull[1]));
      chk("B.ovf",     32'(b_ovf),   32'(movf[1]));
      chk("B.unf",     32'(b_unf),   32'(munf[1]));
    end
  end

  task automatic step(input logic r, input logic s1, input logic rw1, input logic [7:0] d,
                      input logic fl, input logic s2, input logic rw2);
    @(negedge clk);
    rst = r; mode_multi = mm; p1_select = s1; p1_rdnw = rw1; p1_data = d;
    p1_flush = fl; p2_select = s2; p2_rdnw = rw2;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();             step(1, 0, 0, 8'h00, 0, 0, 0); endtask
  task automatic do_wr(input logic [7:0] d); step(0, 1, 0, d, 0, 0, 0); endtask
  task automatic do_rd();              step(0, 0, 0, 8'h00, 0, 1, 1); endtask
  task automatic do_rw(input logic [7:0] d); step(0, 1, 0, d, 0, 1, 1); endtask

  initial begin
    // Single mode basics; B starts holding one zero entry.
    mm = 1'b0;
    do_rst();
    chk_en = 1'b1;
    chk("L.rst A.count", 32'(a_count), 0);
    chk("L.rst A.avail", 32'(a_av), 0);
    chk("L.rst A.data",  32'(a_data), 0);
    chk("L.rst B.count", 32'(b_count), 1);
    chk("L.rst B.avail", 32'(b_av), 1);
    chk("L.rst B.full",  32'(b_full), 1);
    do_wr(8'hA5);
    chk("L.wr A.count", 32'(a_count), 1);
    chk("L.wr A.avail", 32'(a_av), 1);
    chk("L.wr A.full",  32'(a_full), 1);
    do_rd();
    chk("L.rd A.data",  32'(a_data), 32'hA5);
    chk("L.rd A.count", 32'(a_count), 0);
    chk("L.rd A.avail", 32'(a_av), 0);
    chk("L.rd A.full",  32'(a_full), 0);
    chk("L.rd B.data",  32'(b_data), 32'h00);

    // Threshold mode, overflow, simultaneous read/write, empty read.
    mm = 1'b1;
    do_rst();
    do_wr(8'h11);
    chk("L.m1 A.avail", 32'(a_av), 0);
    chk("L.m1 A.full",  32'(a_full), 0);
    do_wr(8'h22);
    chk("L.m2 A.avail", 32'(a_av), 1);
    chk("L.m2 A.full",  32'(a_full), 1);
    do_wr(8'h33);
    chk("L.drop A.ovf",   32'(a_ovf), 1);
    chk("L.drop A.count", 32'(a_count), 2);
    do_rw(8'h44);
    chk("L.rw A.data",  32'(a_data), 32'h11);
    chk("L.rw A.count", 32'(a_count), 2);
    do_rd();
    chk("L.rd2 A.data", 32'(a_data), 32'h22);
    do_rd();
    chk("L.rd3 A.data", 32'(a_data), 32'h44);
    do_rw(8'h55);
    chk("L.er A.unf",   32'(a_unf), 1);
    chk("L.er A.data",  32'(a_data), 32'h44);
    chk("L.er A.count", 32'(a_count), 1);
    do_rd();
    chk("L.er2 A.data", 32'(a_data), 32'h55);

    // Flush with a write to a full FIFO: no overflow, everything empties.
    do_rst();
    do_wr(8'h66);
    do_wr(8'h77);
    step(0, 1, 0, 8'h88, 1, 0, 0);
    chk("L.fl A.count", 32'(a_count), 0);
    chk("L.fl A.full",  32'(a_full), 0);
    chk("L.fl A.ovf",   32'(a_ovf), 0);
    chk("L.fl B.count", 32'(b_count), 0);

    // Reset in the middle of traffic.
    do_wr(8'h99);
    do_rd();
    do_rd();
    do_wr(8'hAA);
    do_rst();
    chk("L.mr A.data",  32'(a_data), 0);
    chk("L.mr A.unf",   32'(a_unf), 0);
    chk("L.mr A.count", 32'(a_count), 0);
    chk("L.mr B.count", 32'(b_count), 1);

    // Pointer wrap on both depths.
    step(0, 0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      do_wr(8'h10 + 8'(i));
      do_rd();
      chk("L.wrap B.data", 32'(b_data), 32'h10 + i);
      chk("L.wrap A.data", 32'(a_data), 32'h10 + i);
    end
    chk("L.wrap B.ovf", 32'(b_ovf), 0);
    chk("L.wrap B.unf", 32'(b_unf), 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) mm = ~mm;
      step($urandom_range(0, 99) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    step(0, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
